cy10lp_qsys_pio_hex_blink: RTL
==============================

CY10LP_QSYS_PIO_HEX_BLINK -- requirements
Module: cy10lp_qsys_pio_hex_blink

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the output port width (legal 1..32).
REQ-002 The module SHALL have parameter RESET_VALUE, default all-ones of DATA_WIDTH, giving the DATA register reset value.
REQ-003 The module SHALL have parameter BLINK_DIV_RESET, default 32'd24_999_999, giving the BLINK_DIV register reset value.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  combinational read data, zero wait states, zero-extended.
REQ-011 out_port  output  DATA_WIDTH  driven pattern (e.g. 7-segment segments, active-low).
REQ-012 blink_phase  output  1  current blink phase.

Function
REQ-013 Register map SHALL be: 0 DATA (R/W), 2 BLINK_MASK (R/W), 3 BLINK_DIV (R/W, 32 bits), 4 OUTSET (W), 5 OUTCLR (W), 6 OUTTGL (W); 1 and 7 reserved.
REQ-014 Write to DATA SHALL load writedata[DATA_WIDTH-1:0]; upper bits ignored.
REQ-015 Write to OUTSET SHALL perform DATA |= writedata[DATA_WIDTH-1:0]; write to OUTCLR, DATA &= ~writedata[DATA_WIDTH-1:0]; write to OUTTGL, DATA ^= writedata[DATA_WIDTH-1:0]; all take effect the cycle after the write.
REQ-016 readdata SHALL return the register contents for addresses 0, 2 and 3, and 0 for write-only or reserved addresses; address is decoded regardless of chipselect.
REQ-017 Writes to reserved addresses SHALL have no effect.
REQ-018 A 32-bit blink counter SHALL increment every cycle; when counter == BLINK_DIV it SHALL reload 0 and blink_phase SHALL invert in the same cycle.
REQ-019 BLINK_DIV=0 SHALL make blink_phase invert every cycle; phase period = 2*(BLINK_DIV+1) cycles.
REQ-020 A write to BLINK_DIV SHALL clear the counter to 0 in the same cycle and SHALL leave blink_phase unchanged.
REQ-021 out_port SHALL equal DATA XOR (BLINK_MASK AND {DATA_WIDTH{blink_phase}}), registered-source, with no added latency beyond the register update.
REQ-022 Writes to DATA/OUTSET/OUTCLR/OUTTGL SHALL NOT affect counter or blink_phase.

Reset
REQ-023 While reset_n=0 at a rising edge: DATA <= RESET_VALUE, BLINK_MASK <= 0, BLINK_DIV <= BLINK_DIV_RESET, counter <= 0, blink_phase <= 0.
REQ-024 Reset SHALL override any simultaneous write, and asserting it mid-blink SHALL restart the phase from 0.
REQ-025 After reset, out_port SHALL equal RESET_VALUE and readdata at address 0 SHALL equal zero-extended RESET_VALUE.

Configuration
REQ-026 Macro CY10LP_PIO_BLINK_EN SHALL compile in the blink feature (BLINK_MASK, BLINK_DIV, counter, blink_phase logic).
REQ-027 Without CY10LP_PIO_BLINK_EN: addresses 2 and 3 SHALL behave as reserved (read 0, writes ignored), blink_phase SHALL be tied 0, out_port SHALL equal DATA; OUTSET/OUTCLR/OUTTGL remain.

Verification
REQ-028 Reset with DATA_WIDTH=16 -> out_port=16'hFFFF, readdata(addr0)=32'h0000FFFF, blink_phase=0.
REQ-029 Write DATA=32'hABCD1234, then OUTCLR=0x00F0, OUTSET=0x8000, OUTTGL=0x0001 -> readdata(addr0) sequence 0x1234, 0x1204, 0x9204, 0x9205.
REQ-030 BLINK_DIV=3, BLINK_MASK=0x00FF, DATA=0xFF00 -> out_port alternates 0xFF00/0xFFFF, each level held exactly 4 cycles.
REQ-031 BLINK_DIV=0 -> blink_phase toggles every cycle; rewrite BLINK_DIV=5 mid-count -> next toggle exactly 6 cycles after the write, phase not altered by the write.
REQ-032 Reset asserted during blinking while a DATA write is presented -> DATA=RESET_VALUE, phase 0, counter 0 next cycle; write lost.
REQ-033 Build without CY10LP_PIO_BLINK_EN: write 0x00FF to address 2 -> readdata(addr2)=0, out_port=DATA unchanged, blink_phase=0.

Source files
------------

// File: rtl/cy10lp_qsys_pio_hex_blink.sv
// Avalon-MM PIO output port with set/clear/toggle aliases and an optional masked blinker.
// The blink feature is compiled in only when CY10LP_PIO_BLINK_EN is defined.
module cy10lp_qsys_pio_hex_blink #(
   parameter int                    DATA_WIDTH      = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = {DATA_WIDTH{1'b1}},
   parameter logic [31:0]           BLINK_DIV_RESET = 32'd24_999_999
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  blink_phase
);

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_MASK = 3'd2;
   localparam logic [2:0] ADDR_DIV  = 3'd3;
   localparam logic [2:0] ADDR_SET  = 3'd4;
   localparam logic [2:0] ADDR_CLR  = 3'd5;
   localparam logic [2:0] ADDR_TGL  = 3'd6;

   logic                  wr;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data;

   assign wr = chipselect & ~write_n;
   assign wd = writedata[DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data <= RESET_VALUE;
      end else if (wr) begin
         case (address)
            ADDR_DATA: data <= wd;
            ADDR_SET:  data <= data | wd;
            ADDR_CLR:  data <= data & ~wd;
            ADDR_TGL:  data <= data ^ wd;
            default:   data <= data;
         endcase
      end
   end

`ifdef CY10LP_PIO_BLINK_EN
   logic [DATA_WIDTH-1:0] mask;
   logic [31:0]           div;
   logic [31:0]           cnt;
   logic                  phase;

   // A divider write restarts the count but keeps the phase, so the next
   // toggle lands exactly div+1 cycles after the write.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask  <= '0;
         div   <= BLINK_DIV_RESET;
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         if (wr && address == ADDR_MASK)
            mask <= wd;
         if (wr && address == ADDR_DIV) begin
            div <= writedata;
            cnt <= '0;
         end else if (cnt == div) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 32'd1;
         end
      end
   end

   assign blink_phase = phase;
   assign out_port    = data ^ (mask & {DATA_WIDTH{phase}});

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: readdata = 32'(data);
         ADDR_MASK: readdata = 32'(mask);
         ADDR_DIV:  readdata = div;
         default:   readdata = '0;
      endcase
   end
`else
   logic unused_ok;
   assign unused_ok   = ^{writedata, BLINK_DIV_RESET};

   assign blink_phase = 1'b0;
   assign out_port    = data;

   always_comb begin
      readdata = '0;
      if (address == ADDR_DATA)
         readdata = 32'(data);
   end
`endif

endmodule
